display_mem_arbiter: RTL and testbench
======================================

// Module: display_mem_arbiter
// PURPOSE
// - Owns the single-port 400x300x6b display RAM; shares it between the VGA scan-out read path,
//   a frame-clear sequencer and the game renderer's pixel-write port.
// - Priority: VGA read > clear sweep > renderer write. The scan-out never stalls.
// - Clear starts at the first vertical_porch_start after request and fills every RAM word.
// PARAMETERS
// - SCENE_W   400  logical scene width (pixels)
// - SCENE_H   300  logical scene height (pixels)
// - ADDR_W    17   RAM address width; must hold SCENE_W*SCENE_H-1 (119999)
// PORTS
// - pixel_clk             in   1   single clock, all logic posedge
// - rst                   in   1   synchronous, active-high reset
// - vga_x / vga_y         in   9   scan-out read coordinates (logical pixels)
// - vga_read              in   1   scan-out read this cycle; RAM is owned by VGA
// - vertical_porch_start  in   1   1-cycle marker at start of vertical blanking
// - vga_rgb               out  6   pixel colour for the VGA timing generator
// - wr_req                in   1   renderer write request; hold until wr_ack
// - wr_x / wr_y / wr_rgb  in   9/9/6  renderer write coordinates and colour; stable while wr_req
// - wr_ack                out  1   1-cycle pulse: request consumed (written or discarded)
// - clr_req               in   1   1-cycle pulse: request full-frame clear
// - clr_rgb               in   6   clear colour, latched with clr_req
// - clr_busy              out  1   clear pending or running
// - clr_done              out  1   1-cycle pulse on the final clear write
// - mem_addr              out  ADDR_W  RAM address = y*SCENE_W + x
// - mem_we                out  1   RAM write enable
// - mem_wdata             out  6   RAM write data
// - mem_rdata             in   6   RAM read data, valid 1 cycle after the read address
// BEHAVIOUR
// - Reset values: wr_ack=0, clr_busy=0, clr_done=0, mem_we=0, vga_rgb=0, FSM=IDLE, clr_cnt=0.
// - Read path: vga_read=1 drives mem_addr from vga_x/vga_y with mem_we=0. rd_q <= vga_read.
//   vga_rgb = rd_q ? mem_rdata : 0. Read latency is 1 cycle.
// - Address arithmetic: y*400 = (y<<8)+(y<<7)+(y<<4). No multiplier. Result is ADDR_W bits.
// - FSM IDLE: clr_req -> CLR_WAIT; latch clr_rgb. clr_busy=1 from the next cycle.
// - FSM CLR_WAIT: vertical_porch_start -> CLR_RUN. clr_req here is ignored.
// - FSM CLR_RUN: each cycle with vga_read=0, write clr_rgb at clr_cnt and increment clr_cnt.
//   A cycle with vga_read=1 pauses the sweep. No address is skipped or written twice.
//   The sweep runs on across frames until done.
// - CLR_RUN exit: the write at clr_cnt=SCENE_W*SCENE_H-1 pulses clr_done in the same cycle.
//   Next cycle: FSM=IDLE, clr_cnt=0, clr_busy=0. clr_req during CLR_RUN is ignored.
// - Renderer grant: wr_req=1 && vga_read=0 && FSM!=CLR_RUN. clr_busy in CLR_WAIT does not block writes.
//   In the grant cycle wr_ack=1. If wr_x<SCENE_W && wr_y<SCENE_H: mem_we=1, addr from wr_x/wr_y,
//   mem_wdata=wr_rgb. Otherwise mem_we=0 (discard, still acked).
// - wr_req ignored while vga_read=1 or FSM=CLR_RUN; requester simply waits (no timeout).
// - Simultaneous clr_req and grantable wr_req in IDLE: the write is granted; the clear only arms.
// - Reset mid-operation: the next cycle returns to IDLE. No clr_done and no wr_ack are issued.
//   RAM contents are left partially cleared.
// - mem_addr/mem_we/mem_wdata are combinational muxes of the current state and inputs; mem_we=0 while rst.
// STRUCTURE
// - Include file display_defs.vh holds SCENE_W, SCENE_H, ADDR_W, the colour width (6)
//   and the FSM state encodings (IDLE=0, CLR_WAIT=1, CLR_RUN=2).
// - One sub-module, scene_addr_calc(x[8:0], y[8:0] -> addr[ADDR_W-1:0]). It has two instances:
//   VGA path and renderer path. The clear path uses the linear clr_cnt directly.
// - Top level: FSM plus clr_cnt, priority mux, rd_q register and ack logic.
// TESTING
// - Reset: hold rst 3 cycles with wr_req=1 and clr_req=1 -> wr_ack=0, clr_busy=0, mem_we=0, vga_rgb=0.
// - Read: vga_read=1, x=3, y=1 -> mem_addr=403, mem_we=0; rdata=6'h15 next cycle -> vga_rgb=6'h15.
// - Priority: vga_read=1 with wr_req x=5, y=2 -> no ack. Drop vga_read -> same cycle mem_we=1,
//   mem_addr=805, wr_ack=1 for exactly 1 cycle.
// - Range: wr_req with x=400, y=10 (also x=0, y=300) -> wr_ack pulse, mem_we stays 0.
// - Clear: clr_req, clr_rgb=6'h2A, porch pulse, vga_read=0 -> 120000 writes, addr 0..119999
//   in order, data 6'h2A. clr_done on addr 119999; clr_busy low the next cycle.
// - Clear stress: random vga_read toggling plus wr_req during the sweep -> no gaps or duplicates,
//   wr_ack only after clr_done. Reset at clr_cnt=500 -> clr_busy=0 next cycle, no clr_done.

Source files
------------

// File: rtl/display_mem_arbiter_pkg.sv
// Shared scene geometry, widths and clear-sequencer state encoding for the
// display RAM arbiter and its address calculator.
package display_mem_arbiter_pkg;

  localparam int unsigned SCENE_W = 400;  // logical scene width in pixels
  localparam int unsigned SCENE_H = 300;  // logical scene height in pixels
  localparam int unsigned ADDR_W  = 17;   // holds SCENE_W*SCENE_H-1 = 119999
  localparam int unsigned COLOR_W = 6;    // 2 bits each of R, G, B
  localparam int unsigned COORD_W = 9;    // x and y coordinate width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_WAIT = 2'd1,
    ST_CLR_RUN  = 2'd2
  } clr_state_e;

  // True when a coordinate lies strictly below its scene limit.
  function automatic logic coord_in_range(input logic [COORD_W-1:0] c,
                                          input logic [COORD_W-1:0] lim);
    return (c < lim);
  endfunction

endpackage

// File: rtl/scene_addr_calc.sv
// Linear RAM address from logical scene coordinates: addr = y*400 + x.
// The multiply by 400 is built from three shifts (256 + 128 + 16) so no
// multiplier is inferred. The sum is truncated to ADDR_W bits.
module scene_addr_calc
  import display_mem_arbiter_pkg::*;
(
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [ADDR_W-1:0]  o_addr
);

  logic [ADDR_W-1:0] w_x_ext;
  logic [ADDR_W-1:0] w_y_ext;

  assign w_x_ext = {{(ADDR_W-COORD_W){1'b0}}, i_x};
  assign w_y_ext = {{(ADDR_W-COORD_W){1'b0}}, i_y};
  assign o_addr  = (w_y_ext << 8) + (w_y_ext << 7) + (w_y_ext << 4) + w_x_ext;

endmodule

// File: rtl/display_mem_arbiter.sv
// Owns the single-port display RAM and shares it between the VGA scan-out
// read (highest priority, never stalls), the full-frame clear sweep and the
// renderer pixel-write port (lowest priority). The clear arms on a request,
// starts at the next vertical porch marker and pauses on every scan-out read
// cycle, so each RAM word is written exactly once.
// P_SCENE_H lets a reduced-height scene be built; the scene width is fixed
// at 400 because the address calculator's shift-add depends on it.
module display_mem_arbiter
  import display_mem_arbiter_pkg::*;
#(
  parameter int unsigned P_SCENE_H = SCENE_H
) (
  input  logic               i_pixel_clk,
  input  logic               i_rst,
  input  logic [8:0]         i_vga_x,
  input  logic [8:0]         i_vga_y,
  input  logic               i_vga_read,
  input  logic               i_vertical_porch_start,
  output logic [5:0]         o_vga_rgb,
  input  logic               i_wr_req,
  input  logic [8:0]         i_wr_x,
  input  logic [8:0]         i_wr_y,
  input  logic [5:0]         i_wr_rgb,
  output logic               o_wr_ack,
  input  logic               i_clr_req,
  input  logic [5:0]         i_clr_rgb,
  output logic               o_clr_busy,
  output logic               o_clr_done,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_we,
  output logic [5:0]         o_mem_wdata,
  input  logic [5:0]         i_mem_rdata
);

  localparam logic [ADDR_W-1:0]  CLR_LAST = ADDR_W'(SCENE_W * P_SCENE_H - 1);
  localparam logic [COORD_W-1:0] W_LIM    = COORD_W'(SCENE_W);
  localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(P_SCENE_H);

  clr_state_e          r_state;
  clr_state_e          w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;
  logic [COLOR_W-1:0]  r_clr_rgb;
  logic [COLOR_W-1:0]  w_clr_rgb_nxt;
  logic                r_rd_q;
  logic                w_clr_write;
  logic                w_clr_last;
  logic                w_wr_grant;
  logic                w_wr_in_scene;
  logic [ADDR_W-1:0]   w_vga_addr;
  logic [ADDR_W-1:0]   w_wr_addr;

  scene_addr_calc u_vga_addr (
    .i_x    (i_vga_x),
    .i_y    (i_vga_y),
    .o_addr (w_vga_addr)
  );

  scene_addr_calc u_wr_addr (
    .i_x    (i_wr_x),
    .i_y    (i_wr_y),
    .o_addr (w_wr_addr)
  );

  assign w_wr_in_scene = coord_in_range(i_wr_x, W_LIM) && coord_in_range(i_wr_y, H_LIM);

  // Clear sequencer: arm on request, wait for porch, sweep on idle RAM cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_rgb_nxt = r_clr_rgb;
    w_clr_write   = 1'b0;
    w_clr_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt   = ST_CLR_WAIT;
          w_clr_rgb_nxt = i_clr_rgb;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_CLR_WAIT: begin
        if (i_vertical_porch_start) begin
          w_state_nxt = ST_CLR_RUN;
        end else begin
          w_state_nxt = ST_CLR_WAIT;
        end
      end
      ST_CLR_RUN: begin
        if (!i_vga_read) begin
          w_clr_write = 1'b1;
          if (r_clr_cnt == CLR_LAST) begin
            w_clr_last    = 1'b1;
            w_state_nxt   = ST_IDLE;
            w_clr_cnt_nxt = {ADDR_W{1'b0}};
          end else begin
            w_clr_cnt_nxt = r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_clr_cnt_nxt = r_clr_cnt;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clr_cnt_nxt = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, sweep counter, latched clear colour and read-valid flag.
  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= {ADDR_W{1'b0}};
      r_clr_rgb <= {COLOR_W{1'b0}};
      r_rd_q    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_clr_rgb <= w_clr_rgb_nxt;
      r_rd_q    <= i_vga_read;
    end
  end

  // RAM port priority mux: scan-out read, then clear sweep, then renderer.
  always_comb begin
    o_mem_addr  = w_vga_addr;
    o_mem_we    = 1'b0;
    o_mem_wdata = {COLOR_W{1'b0}};
    w_wr_grant  = 1'b0;
    if (i_vga_read) begin
      o_mem_addr = w_vga_addr;
    end else if (w_clr_write) begin
      o_mem_addr  = r_clr_cnt;
      o_mem_we    = !i_rst;
      o_mem_wdata = r_clr_rgb;
    end else if (i_wr_req && (r_state != ST_CLR_RUN)) begin
      // Out-of-scene writes are still acknowledged but never reach the RAM.
      w_wr_grant  = 1'b1;
      o_mem_addr  = w_wr_addr;
      o_mem_we    = w_wr_in_scene && !i_rst;
      o_mem_wdata = i_wr_rgb;
    end else begin
      o_mem_addr = w_vga_addr;
    end
  end

  assign o_wr_ack   = w_wr_grant && !i_rst;
  assign o_clr_done = w_clr_last && !i_rst;
  assign o_clr_busy = (r_state != ST_IDLE);
  assign o_vga_rgb  = r_rd_q ? i_mem_rdata : {COLOR_W{1'b0}};

endmodule

// File: tb/tb_display_mem_arbiter.sv
// Directed bench for display_mem_arbiter. Uses a 24-line scene so the full
// clear sweeps stay short; the width and address arithmetic are unchanged.
module tb_display_mem_arbiter;

  localparam int H     = 24;
  localparam int WORDS = 400 * H;
  localparam int LAST  = WORDS - 1;

  logic        clk;
  logic        rst;
  logic [8:0]  vga_x, vga_y;
  logic        vga_read;
  logic        porch;
  logic [5:0]  vga_rgb;
  logic        wr_req;
  logic [8:0]  wr_x, wr_y;
  logic [5:0]  wr_rgb;
  logic        wr_ack;
  logic        clr_req;
  logic [5:0]  clr_rgb;
  logic        clr_busy;
  logic        clr_done;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [5:0]  mem_wdata;
  logic [5:0]  mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  display_mem_arbiter #(.P_SCENE_H(H)) dut (
    .i_pixel_clk            (clk),
    .i_rst                  (rst),
    .i_vga_x                (vga_x),
    .i_vga_y                (vga_y),
    .i_vga_read             (vga_read),
    .i_vertical_porch_start (porch),
    .o_vga_rgb              (vga_rgb),
    .i_wr_req               (wr_req),
    .i_wr_x                 (wr_x),
    .i_wr_y                 (wr_y),
    .i_wr_rgb               (wr_rgb),
    .o_wr_ack               (wr_ack),
    .i_clr_req              (clr_req),
    .i_clr_rgb              (clr_rgb),
    .o_clr_busy             (clr_busy),
    .o_clr_done             (clr_done),
    .o_mem_addr             (mem_addr),
    .o_mem_we               (mem_we),
    .o_mem_wdata            (mem_wdata),
    .i_mem_rdata            (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_addr(input int x, input int y);
    return 17'(y * 400 + x);
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm a clear and fire the porch marker; sweep begins on the cycle after return.
  task automatic start_clear(input logic [5:0] rgb);
    clr_req = 1'b1; clr_rgb = rgb;
    step();
    clr_req = 1'b0; clr_rgb = 6'h00;
    porch = 1'b1;
    step();
    porch = 1'b0;
  endtask

  int exp_a, bad, acks, dones, cyc, vx, vy;
  logic vr;

  initial begin
    rst = 1'b1; vga_x = 9'd0; vga_y = 9'd0; vga_read = 1'b0; porch = 1'b0;
    wr_req = 1'b1; wr_x = 9'd5; wr_y = 9'd2; wr_rgb = 6'h11;
    clr_req = 1'b1; clr_rgb = 6'h2A; mem_rdata = 6'h00;
    #1;

    // Reset held three cycles with requests pending
    step(); step();
    #2;
    check("rst_ack", wr_ack, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_rgb", vga_rgb, 0);
    check("rst_done", clr_done, 0);
    step();
    rst = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
    #2;
    check("post_rst_busy", clr_busy, 0);
    step();

    // Scan-out read with 1-cycle latency
    vga_read = 1'b1; vga_x = 9'd3; vga_y = 9'd1;
    #2;
    check("rd_addr", mem_addr, 403);
    check("rd_we", mem_we, 0);
    step();
    vga_read = 1'b0; mem_rdata = 6'h15;
    #2;
    check("rd_rgb", vga_rgb, 6'h15);
    step();
    #2;
    check("rd_rgb_idle", vga_rgb, 0);
    step();

    // Scan-out blocks a pending write, which goes through once it drops
    vga_read = 1'b1; vga_x = 9'd0; vga_y = 9'd0;
    wr_req = 1'b1; wr_x = 9'd5; wr_y = 9'd2; wr_rgb = 6'h11;
    #2;
    check("pri_ack_blocked", wr_ack, 0);
    check("pri_we_blocked", mem_we, 0);
    step();
    vga_read = 1'b0;
    #2;
    check("pri_we", mem_we, 1);
    check("pri_addr", mem_addr, 805);
    check("pri_wdata", mem_wdata, 6'h11);
    check("pri_ack", wr_ack, 1);
    step();
    wr_req = 1'b0;
    #2;
    check("pri_ack_pulse", wr_ack, 0);
    step();

    // Out-of-scene writes: acked, discarded
    wr_req = 1'b1; wr_x = 9'd400; wr_y = 9'd10;
    #2;
    check("rng_x_ack", wr_ack, 1);
    check("rng_x_we", mem_we, 0);
    step();
    wr_x = 9'd0; wr_y = 9'(H);
    #2;
    check("rng_y_ack", wr_ack, 1);
    check("rng_y_we", mem_we, 0);
    step();
    wr_x = 9'd399; wr_y = 9'(H - 1);
    #2;
    check("rng_corner_we", mem_we, 1);
    check("rng_corner_addr", mem_addr, ref_addr(399, H - 1));
    step();

    // Clear request alongside a grantable write: write wins, clear arms
    wr_x = 9'd1; wr_y = 9'd1; wr_rgb = 6'h07;
    clr_req = 1'b1; clr_rgb = 6'h2A;
    #2;
    check("arm_ack", wr_ack, 1);
    check("arm_addr", mem_addr, 401);
    check("arm_busy", clr_busy, 0);
    step();
    // Waiting for porch: writes still pass; a second clr_req is ignored
    clr_req = 1'b1; clr_rgb = 6'h3F; wr_x = 9'd2; wr_y = 9'd0;
    #2;
    check("wait_busy", clr_busy, 1);
    check("wait_ack", wr_ack, 1);
    check("wait_we", mem_we, 1);
    step();
    clr_req = 1'b0; clr_rgb = 6'h00; wr_req = 1'b0; porch = 1'b1;
    #2;
    check("porch_we", mem_we, 0);
    step();
    porch = 1'b0;

    // Uninterrupted sweep: every address in order, done on the last
    exp_a = 0; bad = 0; dones = 0;
    while (exp_a <= LAST) begin
      #2;
      if (clr_done) dones++;
      if (mem_we !== 1'b1 || mem_addr !== 17'(exp_a) || mem_wdata !== 6'h2A ||
          clr_done !== (exp_a == LAST) || clr_busy !== 1'b1)
        bad++;
      exp_a++;
      step();
    end
    check("sweep_bad", bad, 0);
    check("sweep_dones", dones, 1);
    #2;
    check("sweep_busy_after", clr_busy, 0);
    check("sweep_we_after", mem_we, 0);
    check("sweep_done_after", clr_done, 0);
    step();

    // Stress: random scan-out reads and a held write request during the sweep
    start_clear(6'h15);
    exp_a = 0; bad = 0; acks = 0; dones = 0; cyc = 0;
    wr_req = 1'b1; wr_x = 9'd7; wr_y = 9'd3; wr_rgb = 6'h01;
    while (exp_a <= LAST && cyc < 4 * WORDS) begin
      vr = 1'($urandom_range(0, 1));
      vx = $urandom_range(0, 399);
      vy = $urandom_range(0, H - 1);
      vga_read = vr; vga_x = 9'(vx); vga_y = 9'(vy);
      #2;
      if (wr_ack) acks++;
      if (clr_done) dones++;
      if (vr) begin
        if (mem_we !== 1'b0 || mem_addr !== ref_addr(vx, vy) || clr_done !== 1'b0) bad++;
      end else begin
        if (mem_we !== 1'b1 || mem_addr !== 17'(exp_a) || mem_wdata !== 6'h15 ||
            clr_done !== (exp_a == LAST)) bad++;
        exp_a++;
      end
      step();
      cyc++;
    end
    vga_read = 1'b0;
    check("stress_bound", exp_a, WORDS);
    check("stress_bad", bad, 0);
    check("stress_acks", acks, 0);
    check("stress_dones", dones, 1);
    #2;
    check("stress_busy_after", clr_busy, 0);
    check("stress_ack_after", wr_ack, 1);
    check("stress_addr_after", mem_addr, ref_addr(7, 3));
    step();
    wr_req = 1'b0;

    // Reset partway through a sweep
    start_clear(6'h0C);
    exp_a = 0; bad = 0; dones = 0;
    while (exp_a < 500) begin
      #2;
      if (clr_done) dones++;
      if (mem_we !== 1'b1 || mem_addr !== 17'(exp_a)) bad++;
      exp_a++;
      step();
    end
    check("rstmid_bad", bad, 0);
    rst = 1'b1;
    #2;
    check("rstmid_we", mem_we, 0);
    check("rstmid_done", clr_done, 0);
    step();
    rst = 1'b0;
    #2;
    check("rstmid_busy", clr_busy, 0);
    check("rstmid_idle_we", mem_we, 0);
    check("rstmid_dones", dones, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
